alu_arbiter: RTL and testbench

Shares the single-cycle `alu` datapath (add/mul/div/sub) between two requesters in the processor. Requests are accepted with a valid/ready handshake and arbitrated round-robin. The block drives the ALU operand and opcode ports from registers for an op-dependent number of cycles, then returns the result and zero flag on a per-requester response handshake. Sits between the two issue lanes of the processor and the shared `alu` instance.

---
 rtl/alu_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between two requesters.
// Optional ALU_ARB_DIVZERO_EN: divide-by-zero is answered locally with rsp_err set.
module alu_arbiter #(
    parameter int WIDTH      = 23,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH:0]   req0_a,
    input  logic [WIDTH:0]   req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req0_ci,
    input  logic [WIDTH:0]   req1_a,
    input  logic [WIDTH:0]   req1_b,
    input  logic [1:0]       req1_op,
    input  logic             req1_ci,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH:0]   rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH:0]   alu_a,
    output logic [WIDTH:0]   alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_ci,
    input  logic [WIDTH:0]   alu_out,
    input  logic             alu_cero
);
    localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   a_q, a_d, b_q, b_d, data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic             ci_q, ci_d, zero_q, zero_d;
`ifdef ALU_ARB_DIVZERO_EN
    logic             err_q, err_d;
`endif

    logic [1:0]       grant;
    logic             sel;
    logic [WIDTH:0]   sel_a, sel_b;
    logic [1:0]       sel_op;
    logic             sel_ci;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b1;
            gnt_q    <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            ci_q     <= 1'b0;
            data_q   <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_ARB_DIVZERO_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            ci_q     <= ci_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
`ifdef ALU_ARB_DIVZERO_EN
            err_q    <= err_d;
`endif
        end
    end

    // On a tie, rr_ptr_q names the requester served last, so the other one wins.
    assign sel    = grant[1];
    assign sel_a  = sel ? req1_a  : req0_a;
    assign sel_b  = sel ? req1_b  : req0_b;
    assign sel_op = sel ? req1_op : req0_op;
    assign sel_ci = sel ? req1_ci : req0_ci;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        ci_d     = ci_q;
        data_d   = data_q;
        zero_d   = zero_q;
`ifdef ALU_ARB_DIVZERO_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    gnt_d   = sel;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    op_d    = sel_op;
                    ci_d    = sel_ci;
                    state_d = EXEC;
                    case (sel_op)
                        2'b01:   cnt_d = CNT_W'(MUL_CYCLES);
                        2'b10:   cnt_d = CNT_W'(DIV_CYCLES);
                        default: cnt_d = CNT_W'(1);
                    endcase
`ifdef ALU_ARB_DIVZERO_EN
                    // Answered locally; the ALU keeps its previous operands.
                    if (sel_op == 2'b10 && sel_b == '0) begin
                        a_d     = a_q;
                        b_d     = b_q;
                        op_d    = op_q;
                        ci_d    = ci_q;
                        data_d  = '1;
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
`endif
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    data_d  = alu_out;
                    zero_d  = alu_cero;
`ifdef ALU_ARB_DIVZERO_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
                    rr_ptr_d = gnt_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant     = 2'b00;
        rsp_valid = 2'b00;
        if (state_q == IDLE) begin
            if (&req_valid) grant = rr_ptr_q ? 2'b01 : 2'b10;
            else            grant = req_valid;
        end
        if (state_q == RESP) rsp_valid = gnt_q ? 2'b10 : 2'b01;
        req_ready = grant;
    end

    assign rsp_data = data_q;
    assign rsp_zero = zero_q;
`ifdef ALU_ARB_DIVZERO_EN
    assign rsp_err  = err_q;
`else
    assign rsp_err  = 1'b0;
`endif
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign alu_ci   = ci_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, corner-case sequences, random traffic.
module tb_alu_arbiter;
  localparam int WIDTH = 23;
  localparam int MULC  = 2;
  localparam int DIVC  = 4;
  localparam int SW    = WIDTH + 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     req_valid = 2'b00;
  logic [1:0]     req_ready;
  logic [WIDTH:0] ra [2];
  logic [WIDTH:0] rb [2];
  logic [1:0]     rop [2];
  logic           rci [2];
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready = 2'b11;
  logic [WIDTH:0] rsp_data;
  logic           rsp_zero, rsp_err;
  logic [WIDTH:0] alu_a, alu_b, alu_out;
  logic [1:0]     alu_op;
  logic           alu_ci, alu_cero;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_bp  = 1'b0;
  logic [SW-1:0] exp_q[$];

  alu_arbiter #(.WIDTH(WIDTH), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(ra[0]), .req0_b(rb[0]), .req0_op(rop[0]), .req0_ci(rci[0]),
    .req1_a(ra[1]), .req1_b(rb[1]), .req1_op(rop[1]), .req1_ci(rci[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ci(alu_ci),
    .alu_out(alu_out), .alu_cero(alu_cero)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference single-cycle ALU
  function automatic logic [WIDTH+1:0] alu_calc(logic [WIDTH:0] a, logic [WIDTH:0] b,
                                                logic [1:0] op, logic ci);
    logic [WIDTH:0] r;
    case (op)
      2'b00:   r = a + b + {{WIDTH{1'b0}}, ci};
      2'b01:   r = a * b;
      2'b10:   r = (b == '0) ? '1 : a / b;
      default: r = a - b - {{WIDTH{1'b0}}, ci};
    endcase
    return {(r == '0), r};
  endfunction

  always_comb {alu_cero, alu_out} = alu_calc(alu_a, alu_b, alu_op, alu_ci);

  function automatic logic [SW-1:0] model(bit id, logic [WIDTH:0] a, logic [WIDTH:0] b,
                                          logic [1:0] op, logic ci);
    logic [WIDTH+1:0] zr;
    zr = alu_calc(a, b, op, ci);
`ifdef ALU_ARB_DIVZERO_EN
    if (op == 2'b10 && b == '0) return {1'b1, 1'b0, id, {(WIDTH+1){1'b1}}};
`endif
    return {1'b0, zr[WIDTH+1], id, zr[WIDTH:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare on every response handshake
  always @(negedge clk) begin
    if (rst_n) begin
      check("rsp_valid_onehot", {63'd0, (rsp_valid == 2'b11)}, 64'd0);
      check("req_ready_onehot", {63'd0, (req_ready == 2'b11)}, 64'd0);
      if (|(rsp_valid & rsp_ready)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {36'd0, rsp_err, rsp_zero, rsp_valid[1], rsp_data}, 64'hDEAD);
        end else begin
          check("scoreboard", {36'd0, rsp_err, rsp_zero, rsp_valid[1], rsp_data},
                {36'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // random response backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) rsp_ready = 2'($urandom_range(0, 3));
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input logic [WIDTH:0] a, input logic [WIDTH:0] b,
                       input logic [1:0] op, input logic ci, input logic [SW-1:0] exp);
    bit got = 1'b0;
    ra[id] = a; rb[id] = b; rop[id] = op; rci[id] = ci;
    req_valid[id] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    if (!got) begin
      check("accept_timeout", 64'd0, 64'd1);
      req_valid[id] = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(exp);
      #1;
      req_valid[id] = 1'b0;
    end
  endtask

  task automatic wait_rsp(input bit id, input logic [WIDTH:0] a, input logic [WIDTH:0] b,
                          input logic [1:0] op, output int k);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid[id]) break;
      check("alu_hold", {14'd0, alu_a, alu_b, alu_op}, {14'd0, a, b, op});
      @(posedge clk);
      k++;
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit             id;
    logic [WIDTH:0] a;
    logic [WIDTH:0] b;
    logic [1:0]     op;
    logic           ci;
    int             lat;
    logic [WIDTH:0] d;
    logic           z;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int k;
    bit seen;
    vecs[0] = '{1'b0, 24'd4,       24'd1, 2'b00, 1'b0, 1,    24'd5,  1'b0};
    vecs[1] = '{1'b1, 24'd10,      24'd3, 2'b11, 1'b0, 1,    24'd7,  1'b0};
    vecs[2] = '{1'b0, 24'd6,       24'd7, 2'b01, 1'b0, MULC, 24'd42, 1'b0};
    vecs[3] = '{1'b1, 24'd100,     24'd7, 2'b10, 1'b0, DIVC, 24'd14, 1'b0};
    vecs[4] = '{1'b0, 24'hFFFFFF,  24'd1, 2'b00, 1'b0, 1,    24'd0,  1'b1};
    vecs[5] = '{1'b1, 24'h800000,  24'd2, 2'b01, 1'b0, MULC, 24'd0,  1'b1};
    vecs[6] = '{1'b0, 24'd3,       24'd4, 2'b00, 1'b1, 1,    24'd8,  1'b0};
    vecs[7] = '{1'b1, 24'd4,       24'd1, 2'b10, 1'b0, DIVC, 24'd4,  1'b0};
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0; rb[i] = '0; rop[i] = 2'b00; rci[i] = 1'b0;
    end

    // reset values
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {62'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    check("rst_rsp", {38'd0, rsp_err, rsp_zero, rsp_data}, 64'd0);
    check("rst_alu", {13'd0, alu_a, alu_b, alu_op, alu_ci}, 64'd0);
    do_reset();

    // vector table
    foreach (vecs[i]) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ci,
            {1'b0, vecs[i].z, vecs[i].id, vecs[i].d});
      wait_rsp(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, k);
      check($sformatf("vec%0d_latency", i), 64'(k), 64'(vecs[i].lat));
      check($sformatf("vec%0d_data", i), {39'd0, rsp_zero, rsp_data}, {39'd0, vecs[i].z, vecs[i].d});
    end
    wait_drain();

    // tie after reset: req0 first, then req1, then req0 wins the next tie
    do_reset();
    ra[0] = 24'd5; rb[0] = 24'd5; rop[0] = 2'b01; rci[0] = 1'b0;
    ra[1] = 24'd5; rb[1] = 24'd5; rop[1] = 2'b11; rci[1] = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    check("tie_first_grant", {62'd0, req_ready}, 64'd1);
    @(posedge clk);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 24'd25});
    #1 req_valid[0] = 1'b0;
    issue(1'b1, 24'd5, 24'd5, 2'b11, 1'b0, {1'b0, 1'b1, 1'b1, 24'd0});
    wait_drain();
    req_valid = 2'b11;
    @(negedge clk);
    check("tie_second_grant", {62'd0, req_ready}, 64'd1);
    @(posedge clk);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 24'd25});
    #1 req_valid[0] = 1'b0;
    issue(1'b1, 24'd5, 24'd5, 2'b11, 1'b0, {1'b0, 1'b1, 1'b1, 24'd0});
    wait_drain();

    // backpressure on requester 0 while requester 1 waits
    rsp_ready = 2'b10;
    issue(1'b0, 24'd9, 24'd9, 2'b00, 1'b0, {1'b0, 1'b0, 1'b0, 24'd18});
    ra[1] = 24'd1; rb[1] = 24'd1; rop[1] = 2'b00; rci[1] = 1'b0;
    req_valid[1] = 1'b1;
    wait_rsp(1'b0, 24'd9, 24'd9, 2'b00, k);
    check("bp_latency", 64'(k), 64'd1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_hold", {36'd0, rsp_valid, rsp_err, rsp_zero, rsp_data}, {36'd0, 2'b01, 2'b00, 24'd18});
      check("bp_req_ready", {62'd0, req_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_req1_next", {62'd0, req_ready}, 64'd2);
    @(posedge clk);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 24'd2});
    #1 req_valid[1] = 1'b0;
    wait_drain();

    // reset in the middle of a divide
    issue(1'b0, 24'd100, 24'd5, 2'b10, 1'b0, {1'b0, 1'b0, 1'b0, 24'd20});
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rsp", {36'd0, rsp_valid, req_ready, rsp_err, rsp_zero, rsp_data}, 64'd0);
    check("midrst_alu", {13'd0, alu_a, alu_b, alu_op, alu_ci}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    check("midrst_no_rsp", {63'd0, seen}, 64'd0);
    @(posedge clk);
    #1;

    // divide by zero
`ifdef ALU_ARB_DIVZERO_EN
    issue(1'b0, 24'd7, 24'd0, 2'b10, 1'b0, {1'b1, 1'b0, 1'b0, 24'hFFFFFF});
    @(negedge clk);
    check("dz_fast_rsp", {62'd0, rsp_valid}, 64'd1);
    check("dz_rsp", {39'd0, rsp_err, rsp_data}, {39'd0, 1'b1, 24'hFFFFFF});
    check("dz_alu_unchanged", {13'd0, alu_a, alu_b, alu_op, alu_ci}, 64'd0);
`else
    issue(1'b0, 24'd7, 24'd0, 2'b10, 1'b0, {1'b0, 1'b0, 1'b0, 24'hFFFFFF});
    wait_rsp(1'b0, 24'd7, 24'd0, 2'b10, k);
    check("dz_latency", 64'(k), 64'(DIVC));
    check("dz_err", {63'd0, rsp_err}, 64'd0);
`endif
    wait_drain();
    issue(1'b1, 24'd2, 24'd3, 2'b00, 1'b0, {1'b0, 1'b0, 1'b1, 24'd5});
    wait_rsp(1'b1, 24'd2, 24'd3, 2'b00, k);
    check("after_dz_err", {63'd0, rsp_err}, 64'd0);
    wait_drain();

    // random traffic with random response backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bit             id;
      logic [WIDTH:0] a, b;
      logic [1:0]     op;
      logic           ci;
      id = 1'($urandom_range(0, 1));
      a  = (WIDTH+1)'($urandom);
      b  = ($urandom_range(0, 4) == 0) ? '0 : (WIDTH+1)'($urandom_range(0, 4095));
      op = 2'($urandom_range(0, 3));
      ci = 1'($urandom_range(0, 1));
      issue(id, a, b, op, ci, model(id, a, b, op, ci));
    end
    wait_drain();
    rand_bp = 1'b0;
    @(negedge clk);
    rsp_ready = 2'b11;
    repeat (2) @(posedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
